perf_mon_mc: RTL and testbench
==============================

PERF_MON_MC -- requirements
Module: perf_mon_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of monitored Avalon-MM master channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of each per-channel counter and of each cycle-counter half (16..48).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 ddr3_clk  in  1  sole clock, all logic on rising edge.
REQ-005 ddr3_reset_n  in  1  asynchronous active-low reset.
REQ-006 clr  in  1  zero all counters and sticky flags, return FSM to IDLE.
REQ-007 start  in  1  begin or resume counting.
REQ-008 stop  in  1  freeze counting.
REQ-009 m_read, m_write, m_waitrequest, m_readdatavalid  in  NUM_CH each  per-channel bus strobes, bit i = channel i.
REQ-010 rd_sel  in  $clog2(NUM_CH) (min 1)  channel selected for readout.
REQ-011 rd_cnt, wr_cnt, stall_cnt  out  CNT_W each  counters of the selected channel.
REQ-012 ovf  out  1  sticky overflow flag of the selected channel.
REQ-013 cycle_cnt_l, cycle_cnt_h  out  CNT_W each  low/high halves of the RUN-cycle counter.
REQ-014 state  out  2  FSM state encoding (IDLE=0, RUN=1, FROZEN=2).

Function
REQ-015 FSM SHALL transition IDLE->RUN and FROZEN->RUN on start, RUN->FROZEN on stop, any state->IDLE on clr; no other transitions.
REQ-016 Simultaneous control priority SHALL be clr > start > stop; start and stop together in RUN keep RUN.
REQ-017 All counters SHALL increment only in cycles where registered state is RUN; clr zeroes them on the following edge.
REQ-018 Per channel i: rd_cnt +1 on m_readdatavalid[i]; wr_cnt +1 on m_write[i] & ~m_waitrequest[i]; stall_cnt +1 on (m_read[i] | m_write[i]) & m_waitrequest[i].
REQ-019 Event in cycle t SHALL be reflected in counter register at edge ending cycle t (one-cycle latency).
REQ-020 Cycle counter SHALL increment every RUN cycle; cycle_cnt_h increments in the same cycle cycle_cnt_l wraps from all-ones to zero.
REQ-021 Readout outputs SHALL be registered: value presented in cycle t+1 = counters of rd_sel sampled at cycle t (one-cycle latency).
REQ-022 rd_sel >= NUM_CH SHALL drive rd_cnt, wr_cnt, stall_cnt and ovf to zero.
REQ-023 Channel ovf SHALL set when any of its three counters would exceed all-ones; cleared only by clr or reset.
REQ-024 Events arriving in IDLE or FROZEN SHALL be ignored; counter values held in FROZEN.

Reset
REQ-025 On ddr3_reset_n low: state=IDLE, all counters, ovf flags and all outputs = 0, asynchronously.
REQ-026 Reset asserted mid-RUN SHALL discard counts; after release block waits in IDLE for start.

Configuration
REQ-027 Macro PERF_MON_MC_SAT_EN defined: per-channel counters saturate at all-ones (cycle counter still carries to high half, saturates at 2*CNT_W all-ones).
REQ-028 Macro PERF_MON_MC_SAT_EN undefined: all counters wrap to zero; ovf still set on wrap.

Structure
REQ-029 Package perf_mon_mc_pkg SHALL hold state typedef/encoding (IDLE, RUN, FROZEN) and width limits.
REQ-030 Sub-module perf_cnt SHALL implement one CNT_W counter with inc, clr, en, ovf and the saturation option; instantiated 3*NUM_CH times.

Verification
REQ-031 start, 10 cycles m_readdatavalid[1]=1, stop, rd_sel=1 -> rd_cnt=10, state=2, cycle_cnt_l = RUN cycles exactly.
REQ-032 Ch0 m_write=1 with m_waitrequest high 3 cycles then low 5 cycles in RUN -> wr_cnt=5, stall_cnt=3.
REQ-033 CNT_W=16, force 65537 read beats ch2 -> SAT_EN: rd_cnt=16'hFFFF, ovf=1; no SAT_EN: rd_cnt=1, ovf=1.
REQ-034 clr, start, stop same cycle in RUN -> next state IDLE, all counters 0.
REQ-035 CNT_W=16, RUN 65536 cycles -> cycle_cnt_l=0, cycle_cnt_h=1.
REQ-036 Drop ddr3_reset_n mid-RUN with counts nonzero -> all outputs 0 immediately, state IDLE, events ignored until start.

Source files
------------

// File: rtl/perf_mon_mc_pkg.sv
// Shared state encoding and parameter limits for the multi-channel perf monitor.
// No logic of its own, so there is no latency or backpressure.
package perf_mon_mc_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    localparam int MIN_CH    = 1;
    localparam int MAX_CH    = 16;
    localparam int MIN_CNT_W = 16;
    localparam int MAX_CNT_W = 48;
endpackage

// File: rtl/perf_mon_mc_cnt.sv
// perf_cnt: one event counter with a sticky overflow flag. With PERF_MON_MC_SAT_EN it saturates, otherwise it wraps.
// Latency: an increment shows at the edge that ends its cycle. There is no backpressure.
module perf_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         ovf
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (en && inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
`ifdef PERF_MON_MC_SAT_EN
                cnt <= cnt;
`else
                cnt <= '0;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/perf_mon_mc.sv
// Avalon-MM performance monitor: per-channel read/write/stall counters plus a RUN-cycle counter. The saturation option is PERF_MON_MC_SAT_EN.
// Latency: counters update one cycle after an event, and readout shows them one cycle after that. There is no backpressure.
module perf_mon_mc
    import perf_mon_mc_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                                       ddr3_clk,
    input  logic                                       ddr3_reset_n,
    input  logic                                       clr,
    input  logic                                       start,
    input  logic                                       stop,
    input  logic [NUM_CH-1:0]                          m_read,
    input  logic [NUM_CH-1:0]                          m_write,
    input  logic [NUM_CH-1:0]                          m_waitrequest,
    input  logic [NUM_CH-1:0]                          m_readdatavalid,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
    output logic [CNT_W-1:0]                           rd_cnt,
    output logic [CNT_W-1:0]                           wr_cnt,
    output logic [CNT_W-1:0]                           stall_cnt,
    output logic                                       ovf,
    output logic [CNT_W-1:0]                           cycle_cnt_l,
    output logic [CNT_W-1:0]                           cycle_cnt_h,
    output logic [1:0]                                 state
);
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t               state_q;
    logic                 run;
    logic [2*CNT_W-1:0]   cyc_q;
    logic [CNT_W-1:0]     rd_arr [NUM_CH];
    logic [CNT_W-1:0]     wr_arr [NUM_CH];
    logic [CNT_W-1:0]     st_arr [NUM_CH];
    logic [NUM_CH-1:0]    ovf_ch;
    logic [CNT_W-1:0]     rd_mux, wr_mux, st_mux;
    logic                 ovf_mux;

    assign run         = (state_q == RUN);
    assign state       = state_q;
    assign cycle_cnt_l = cyc_q[CNT_W-1:0];
    assign cycle_cnt_h = cyc_q[2*CNT_W-1:CNT_W];

    // Control priority is clr > start > stop, so start together with stop in RUN stays in RUN.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state_q <= IDLE;
        end else if (clr) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_q <= RUN;
                RUN:     if (stop && !start) state_q <= FROZEN;
                FROZEN:  if (start) state_q <= RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    // The two halves form one 2*CNT_W counter, so the high half carries when the low half wraps.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            cyc_q <= '0;
        end else if (clr) begin
            cyc_q <= '0;
        end else if (run) begin
`ifdef PERF_MON_MC_SAT_EN
            if (!(&cyc_q)) cyc_q <= cyc_q + 1'b1;
`else
            cyc_q <= cyc_q + 1'b1;
`endif
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [2:0] ovf3;

        perf_cnt #(.W(CNT_W)) u_rd (
            .clk(ddr3_clk), .rst_n(ddr3_reset_n), .clr(clr), .en(run),
            .inc(m_readdatavalid[i]), .cnt(rd_arr[i]), .ovf(ovf3[0]));

        perf_cnt #(.W(CNT_W)) u_wr (
            .clk(ddr3_clk), .rst_n(ddr3_reset_n), .clr(clr), .en(run),
            .inc(m_write[i] & ~m_waitrequest[i]), .cnt(wr_arr[i]), .ovf(ovf3[1]));

        perf_cnt #(.W(CNT_W)) u_st (
            .clk(ddr3_clk), .rst_n(ddr3_reset_n), .clr(clr), .en(run),
            .inc((m_read[i] | m_write[i]) & m_waitrequest[i]), .cnt(st_arr[i]), .ovf(ovf3[2]));

        assign ovf_ch[i] = |ovf3;
    end

    // No channel matches an out-of-range rd_sel, so the mux falls through to zero.
    always_comb begin
        rd_mux  = '0;
        wr_mux  = '0;
        st_mux  = '0;
        ovf_mux = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                rd_mux  = rd_arr[i];
                wr_mux  = wr_arr[i];
                st_mux  = st_arr[i];
                ovf_mux = ovf_ch[i];
            end
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            stall_cnt <= '0;
            ovf       <= 1'b0;
        end else begin
            rd_cnt    <= rd_mux;
            wr_cnt    <= wr_mux;
            stall_cnt <= st_mux;
            ovf       <= ovf_mux;
        end
    end
endmodule

// File: tb/tb_perf_mon_mc.sv
// Directed self-checking bench for perf_mon_mc (NUM_CH=3 so rd_sel=3 is out of range, CNT_W=16).
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled there once they have settled.
module tb_perf_mon_mc;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;

    logic              ddr3_clk = 1'b0;
    logic              ddr3_reset_n;
    logic              clr, start, stop;
    logic [NUM_CH-1:0] m_read, m_write, m_waitrequest, m_readdatavalid;
    logic [1:0]        rd_sel;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt, stall_cnt, cycle_cnt_l, cycle_cnt_h;
    logic              ovf;
    logic [1:0]        state;

    int checks = 0;
    int errors = 0;

    perf_mon_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n),
        .clr(clr), .start(start), .stop(stop),
        .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
        .m_readdatavalid(m_readdatavalid), .rd_sel(rd_sel),
        .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .stall_cnt(stall_cnt), .ovf(ovf),
        .cycle_cnt_l(cycle_cnt_l), .cycle_cnt_h(cycle_cnt_h), .state(state));

    always #5 ddr3_clk = ~ddr3_clk;

    task automatic step();
        @(posedge ddr3_clk);
        #1;
    endtask

    task automatic test_reset();
        ddr3_reset_n = 1'b0;
        clr = 0; start = 0; stop = 0;
        m_read = '0; m_write = '0; m_waitrequest = '0; m_readdatavalid = '0;
        rd_sel = '0;
        #3;
        checks++; if ({rd_cnt, wr_cnt, stall_cnt, ovf} !== '0) begin errors++; $display("FAIL reset_readout got %h exp 0", {rd_cnt, wr_cnt, stall_cnt, ovf}); end
        checks++; if ({cycle_cnt_h, cycle_cnt_l} !== '0) begin errors++; $display("FAIL reset_cycle got %h exp 0", {cycle_cnt_h, cycle_cnt_l}); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        step();
        ddr3_reset_n = 1'b1;
        step();
        stop = 1; step(); stop = 0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_stop_state got %0d exp 0", state); end
    endtask

    task automatic test_run_count();
        start = 1; step(); start = 0;
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL run_state got %0d exp 1", state); end
        for (int k = 0; k < 10; k++) begin
            m_readdatavalid = 3'b010;
            stop = (k == 9);
            step();
        end
        m_readdatavalid = '0; stop = 0;
        rd_sel = 2'd1; step();
        checks++; if (rd_cnt !== 16'd10) begin errors++; $display("FAIL run_rd_cnt got %0d exp 10", rd_cnt); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL frozen_state got %0d exp 2", state); end
        checks++; if (cycle_cnt_l !== 16'd10 || cycle_cnt_h !== 16'd0) begin errors++; $display("FAIL run_cycles got %0d/%0d exp 0/10", cycle_cnt_h, cycle_cnt_l); end
        m_readdatavalid = 3'b111; m_write = 3'b111; m_waitrequest = 3'b010;
        for (int k = 0; k < 3; k++) step();
        m_readdatavalid = '0; m_write = '0; m_waitrequest = '0;
        step();
        checks++; if (rd_cnt !== 16'd10 || wr_cnt !== 16'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL frozen_hold got %0d/%0d/%0d exp 10/0/0", rd_cnt, wr_cnt, stall_cnt); end
        checks++; if (cycle_cnt_l !== 16'd10) begin errors++; $display("FAIL frozen_cycle got %0d exp 10", cycle_cnt_l); end
        rd_sel = 2'd0; step();
        checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL other_ch got %0d exp 0", rd_cnt); end
    endtask

    task automatic test_write_stall();
        clr = 1; step(); clr = 0;
        start = 1; step(); start = 0;
        m_write = 3'b001;
        for (int k = 0; k < 8; k++) begin
            m_waitrequest = (k < 3) ? 3'b001 : 3'b000;
            stop = (k == 7);
            step();
        end
        m_write = '0; m_waitrequest = '0; stop = 0;
        rd_sel = 2'd0; step();
        checks++; if (wr_cnt !== 16'd5) begin errors++; $display("FAIL wr_cnt got %0d exp 5", wr_cnt); end
        checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d exp 3", stall_cnt); end
        checks++; if (rd_cnt !== 16'd0 || ovf !== 1'b0) begin errors++; $display("FAIL ch0_rd_ovf got %0d/%0b exp 0/0", rd_cnt, ovf); end
        checks++; if (cycle_cnt_l !== 16'd8) begin errors++; $display("FAIL ws_cycle got %0d exp 8", cycle_cnt_l); end
        // Stall via read, then resume from FROZEN.
        start = 1; step(); start = 0;
        m_read = 3'b001; m_waitrequest = 3'b001; stop = 1; step();
        m_read = '0; m_waitrequest = '0; stop = 0; step();
        checks++; if (stall_cnt !== 16'd4 || state !== 2'd2) begin errors++; $display("FAIL rd_stall got %0d st %0d exp 4 st 2", stall_cnt, state); end
    endtask

    task automatic test_back_to_back();
        start = 1; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state got %0d exp 1", state); end
        stop = 1; step();
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_stop_state got %0d exp 1", state); end
        start = 0; stop = 0;
        m_readdatavalid = 3'b011; step(); m_readdatavalid = '0;
        clr = 1; start = 1; stop = 1; step();
        clr = 0; start = 0; stop = 0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clr_state got %0d exp 0", state); end
        checks++; if ({cycle_cnt_h, cycle_cnt_l} !== '0) begin errors++; $display("FAIL clr_cycle got %0d exp 0", cycle_cnt_l); end
        step();
        checks++; if ({rd_cnt, wr_cnt, stall_cnt, ovf} !== '0) begin errors++; $display("FAIL clr_ch0 got %h exp 0", {rd_cnt, wr_cnt, stall_cnt, ovf}); end
        rd_sel = 2'd1; step();
        checks++; if (rd_cnt !== 16'd0) begin errors++; $display("FAIL clr_ch1 got %0d exp 0", rd_cnt); end
    endtask

    task automatic test_overflow();
        logic [CNT_W-1:0] exp_wrap, exp_after;
`ifdef PERF_MON_MC_SAT_EN
        exp_wrap = 16'hFFFF; exp_after = 16'hFFFF;
`else
        exp_wrap = 16'h0000; exp_after = 16'h0001;
`endif
        start = 1; step(); start = 0;
        m_readdatavalid = 3'b100;
        for (int k = 0; k < 65536; k++) begin
            stop = (k == 65535);
            step();
        end
        m_readdatavalid = '0; stop = 0;
        checks++; if (cycle_cnt_l !== 16'd0 || cycle_cnt_h !== 16'd1) begin errors++; $display("FAIL cycle_carry got %0d/%0d exp 1/0", cycle_cnt_h, cycle_cnt_l); end
        rd_sel = 2'd2; step();
        checks++; if (rd_cnt !== exp_wrap || ovf !== 1'b1) begin errors++; $display("FAIL ovf_65536 got %h/%0b exp %h/1", rd_cnt, ovf, exp_wrap); end
        start = 1; step(); start = 0;
        m_readdatavalid = 3'b100; stop = 1; step();
        m_readdatavalid = '0; stop = 0; step();
        checks++; if (rd_cnt !== exp_after || ovf !== 1'b1) begin errors++; $display("FAIL ovf_65537 got %h/%0b exp %h/1", rd_cnt, ovf, exp_after); end
        checks++; if (cycle_cnt_l !== 16'd1 || cycle_cnt_h !== 16'd1) begin errors++; $display("FAIL cycle_65537 got %0d/%0d exp 1/1", cycle_cnt_h, cycle_cnt_l); end
        rd_sel = 2'd1; step();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_ch1 got %0b exp 0", ovf); end
        m_readdatavalid = 3'b100;
        rd_sel = 2'd3; step();
        m_readdatavalid = '0;
        checks++; if ({rd_cnt, wr_cnt, stall_cnt, ovf} !== '0) begin errors++; $display("FAIL sel_oob got %h exp 0", {rd_cnt, wr_cnt, stall_cnt, ovf}); end
        clr = 1; step(); clr = 0;
        rd_sel = 2'd2; step();
        checks++; if (rd_cnt !== 16'd0 || ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %h/%0b exp 0/0", rd_cnt, ovf); end
    endtask

    task automatic test_reset_mid_run();
        rd_sel = 2'd1;
        start = 1; step(); start = 0;
        m_readdatavalid = 3'b010;
        for (int k = 0; k < 3; k++) step();
        checks++; if (rd_cnt !== 16'd2) begin errors++; $display("FAIL pre_reset got %0d exp 2", rd_cnt); end
        ddr3_reset_n = 1'b0;
        #1;
        checks++; if ({rd_cnt, wr_cnt, stall_cnt, ovf, cycle_cnt_h, cycle_cnt_l, state} !== '0) begin errors++; $display("FAIL async_reset got rd %0d cyc %0d st %0d exp 0", rd_cnt, cycle_cnt_l, state); end
        step();
        ddr3_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) step();
        checks++; if (rd_cnt !== 16'd0 || cycle_cnt_l !== 16'd0 || state !== 2'd0) begin errors++; $display("FAIL post_reset_idle got rd %0d cyc %0d st %0d exp 0", rd_cnt, cycle_cnt_l, state); end
        start = 1; step(); start = 0;
        stop = 0; step();
        stop = 1; step();
        m_readdatavalid = '0; stop = 0; step();
        checks++; if (rd_cnt !== 16'd2 || cycle_cnt_l !== 16'd2) begin errors++; $display("FAIL restart got rd %0d cyc %0d exp 2/2", rd_cnt, cycle_cnt_l); end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_write_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
